// File: rtl/ex_mem_stage_if.sv
// Execute-to-memory stage bus: instruction from execute, EX/MEM register contents,
// memory-side backpressure and the PC redirect.
interface ex_mem_stage_if;
  // Execute side
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_pc;
  logic [4:0]  ex_opcode;
  logic [2:0]  ex_func3;
  logic [4:0]  ex_rd;
  logic [31:0] ex_rs1_data;
  logic [31:0] ex_rs2_data;
  logic [31:0] ex_imm;
  logic [31:0] alu_out;
  logic        flush;

  // Memory side
  logic        mem_ready;
  logic        mem_valid;
  logic [4:0]  mem_opcode;
  logic [2:0]  mem_func3;
  logic [4:0]  mem_rd;
  logic [31:0] mem_result;
  logic        mem_reg_write;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_misalign;

  // Fetch redirect
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output ex_valid, ex_pc, ex_opcode, ex_func3, ex_rd, ex_rs1_data, ex_rs2_data, ex_imm,
           alu_out, flush, mem_ready,
    input  ex_ready, mem_valid, mem_opcode, mem_func3, mem_rd, mem_result, mem_reg_write,
           mem_read, mem_write, mem_wdata, mem_wstrb, mem_misalign, redirect_valid, redirect_pc
  );

  modport slave (
    input  ex_valid, ex_pc, ex_opcode, ex_func3, ex_rd, ex_rs1_data, ex_rs2_data, ex_imm,
           alu_out, flush, mem_ready,
    output ex_ready, mem_valid, mem_opcode, mem_func3, mem_rd, mem_result, mem_reg_write,
           mem_read, mem_write, mem_wdata, mem_wstrb, mem_misalign, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ex_mem_stage.sv
// RV32I EX/MEM pipeline register: latches ALU result and control, resolves branches/jumps
// into a one-cycle redirect pulse, and formats store data/strobes for the data memory.
module ex_mem_stage (
  input logic           clk,
  input logic           rst_n,
  ex_mem_stage_if.slave bus
);
  localparam logic [4:0] OpLui    = 5'b01101;
  localparam logic [4:0] OpAuipc  = 5'b00101;
  localparam logic [4:0] OpLoad   = 5'b00000;
  localparam logic [4:0] OpStore  = 5'b01000;
  localparam logic [4:0] OpJal    = 5'b11011;
  localparam logic [4:0] OpJalr   = 5'b11001;
  localparam logic [4:0] OpBranch = 5'b11000;
  localparam logic [4:0] OpImm    = 5'b00100;
  localparam logic [4:0] OpReg    = 5'b01100;

  logic        accept;
  logic [1:0]  addr_lo;
  logic        is_load, is_store;
  logic        reg_write_d, misalign_d;
  logic [31:0] wdata_d;
  logic [3:0]  wstrb_d;
  logic        take_redirect;
  logic [31:0] target_d;

  logic        mem_valid_q, mem_valid_d;
  logic        redirect_valid_q;
  logic [31:0] redirect_pc_q;
  logic [4:0]  opcode_q, rd_q;
  logic [2:0]  func3_q;
  logic [31:0] result_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic        reg_write_q, read_q, write_q, misalign_q;

  assign bus.ex_ready = ~mem_valid_q | bus.mem_ready;
  // Wrong-path instructions arriving during a redirect pulse are dropped, not stalled.
  assign accept = bus.ex_valid & bus.ex_ready & ~redirect_valid_q & ~bus.flush;

  assign addr_lo  = bus.alu_out[1:0];
  assign is_load  = (bus.ex_opcode == OpLoad);
  assign is_store = (bus.ex_opcode == OpStore);

  always_comb begin
    reg_write_d = 1'b0;
    unique case (bus.ex_opcode)
      OpLui, OpAuipc, OpLoad, OpJal, OpJalr, OpImm, OpReg: reg_write_d = (bus.ex_rd != 5'd0);
      default:                                            reg_write_d = 1'b0;
    endcase
  end

  always_comb begin
    wdata_d    = 32'd0;
    wstrb_d    = 4'd0;
    misalign_d = 1'b0;
    if (is_store) begin
      unique case (bus.ex_func3)
        3'b000: begin
          wdata_d = {4{bus.ex_rs2_data[7:0]}};
          wstrb_d = 4'b0001 << addr_lo;
        end
        3'b001: begin
          wdata_d    = {2{bus.ex_rs2_data[15:0]}};
          misalign_d = addr_lo[0];
          wstrb_d    = addr_lo[0] ? 4'b0000 : (4'b0011 << addr_lo);
        end
        3'b010: begin
          wdata_d    = bus.ex_rs2_data;
          misalign_d = (addr_lo != 2'b00);
          wstrb_d    = (addr_lo == 2'b00) ? 4'b1111 : 4'b0000;
        end
        default: wdata_d = bus.ex_rs2_data;
      endcase
    end else if (is_load) begin
      unique case (bus.ex_func3)
        3'b001, 3'b101: misalign_d = addr_lo[0];
        3'b010:         misalign_d = (addr_lo != 2'b00);
        default:        misalign_d = 1'b0;
      endcase
    end
  end

  always_comb begin
    take_redirect = 1'b0;
    target_d      = bus.ex_pc + bus.ex_imm;
    unique case (bus.ex_opcode)
      OpBranch: take_redirect = bus.alu_out[0];
      OpJal:    take_redirect = 1'b1;
      OpJalr: begin
        take_redirect = 1'b1;
        target_d      = (bus.ex_rs1_data + bus.ex_imm) & 32'hFFFF_FFFE;
      end
      default:  take_redirect = 1'b0;
    endcase
  end

  // Flush beats accept; a drain without a refill empties the register.
  always_comb begin
    mem_valid_d = mem_valid_q;
    if (bus.flush) begin
      mem_valid_d = 1'b0;
    end else if (accept) begin
      mem_valid_d = 1'b1;
    end else if (mem_valid_q && bus.mem_ready) begin
      mem_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid_q      <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'd0;
    end else begin
      mem_valid_q      <= mem_valid_d;
      redirect_valid_q <= accept & take_redirect;
      if (accept && take_redirect) begin
        redirect_pc_q <= target_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q    <= 5'd0;
      func3_q     <= 3'd0;
      rd_q        <= 5'd0;
      result_q    <= 32'd0;
      wdata_q     <= 32'd0;
      wstrb_q     <= 4'd0;
      reg_write_q <= 1'b0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      misalign_q  <= 1'b0;
    end else if (accept) begin
      opcode_q    <= bus.ex_opcode;
      func3_q     <= bus.ex_func3;
      rd_q        <= bus.ex_rd;
      result_q    <= bus.alu_out;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      reg_write_q <= reg_write_d;
      read_q      <= is_load;
      write_q     <= is_store && (wstrb_d != 4'd0);
      misalign_q  <= misalign_d;
    end
  end

  assign bus.mem_valid      = mem_valid_q;
  assign bus.mem_opcode     = opcode_q;
  assign bus.mem_func3      = func3_q;
  assign bus.mem_rd         = rd_q;
  assign bus.mem_result     = result_q;
  assign bus.mem_reg_write  = reg_write_q;
  assign bus.mem_read       = read_q;
  assign bus.mem_write      = write_q;
  assign bus.mem_wdata      = wdata_q;
  assign bus.mem_wstrb      = wstrb_q;
  assign bus.mem_misalign   = misalign_q;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios plus randomized traffic,
// compared every cycle against a transaction-level reference model.
module tb_ex_mem_stage;
  localparam logic [4:0] OpLui    = 5'b01101;
  localparam logic [4:0] OpAuipc  = 5'b00101;
  localparam logic [4:0] OpLoad   = 5'b00000;
  localparam logic [4:0] OpStore  = 5'b01000;
  localparam logic [4:0] OpJal    = 5'b11011;
  localparam logic [4:0] OpJalr   = 5'b11001;
  localparam logic [4:0] OpBranch = 5'b11000;
  localparam logic [4:0] OpImm    = 5'b00100;
  localparam logic [4:0] OpReg    = 5'b01100;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [31:0] alu;
  } txn_t;

  typedef struct {
    logic [4:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] res;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        rw;
    logic        rd_en;
    logic        wr;
    logic        mis;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_mem_stage_if bus ();

  ex_mem_stage dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference model state
  bit          m_valid;
  exp_t        m;
  bit          r_valid;
  logic [31:0] r_pc;

  logic [4:0] op_list [9] = '{OpLui, OpAuipc, OpLoad, OpStore, OpJal, OpJalr, OpBranch,
                              OpImm, OpReg};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t predict(input txn_t t);
    exp_t e;
    int   a;
    a       = int'(t.alu % 4);
    e.op    = t.op;
    e.f3    = t.f3;
    e.rd    = t.rd;
    e.res   = t.alu;
    e.rw    = (t.op inside {OpLui, OpAuipc, OpLoad, OpJal, OpJalr, OpImm, OpReg}) && (t.rd != 0);
    e.rd_en = (t.op == OpLoad);
    e.wdata = 32'd0;
    e.strb  = 4'd0;
    e.mis   = 1'b0;
    if (t.op == OpStore) begin
      if (t.f3 == 3'd0) begin
        e.wdata = (t.rs2 & 32'hFF) * 32'h0101_0101;
        e.strb  = 4'(1 << a);
      end else if (t.f3 == 3'd1) begin
        e.wdata = (t.rs2 & 32'hFFFF) * 32'h0001_0001;
        e.mis   = (a % 2 != 0);
        e.strb  = e.mis ? 4'd0 : 4'(3 << a);
      end else if (t.f3 == 3'd2) begin
        e.wdata = t.rs2;
        e.mis   = (a != 0);
        e.strb  = e.mis ? 4'd0 : 4'hF;
      end
    end else if (t.op == OpLoad) begin
      if (t.f3 == 3'd1 || t.f3 == 3'd5) e.mis = (a % 2 != 0);
      else if (t.f3 == 3'd2)            e.mis = (a != 0);
    end
    e.wr = (t.op == OpStore) && (e.strb != 0);
    return e;
  endfunction

  function automatic bit redirects(input txn_t t, output logic [31:0] tgt);
    tgt = t.pc + t.imm;
    if (t.op == OpJalr) tgt = (t.rs1 + t.imm) & ~32'd1;
    return (t.op == OpJal) || (t.op == OpJalr) || (t.op == OpBranch && t.alu % 2 == 1);
  endfunction

  task automatic model_reset();
    m_valid = 0;
    r_valid = 0;
    r_pc    = 32'd0;
    m       = '{op: 5'd0, f3: 3'd0, rd: 5'd0, res: 32'd0, wdata: 32'd0, strb: 4'd0,
                rw: 1'b0, rd_en: 1'b0, wr: 1'b0, mis: 1'b0};
  endtask

  task automatic check_all();
    chk("mem_valid", 32'(bus.mem_valid), 32'(m_valid));
    chk("redirect_valid", 32'(bus.redirect_valid), 32'(r_valid));
    chk("redirect_pc", bus.redirect_pc, r_pc);
    chk("mem_opcode", 32'(bus.mem_opcode), 32'(m.op));
    chk("mem_func3", 32'(bus.mem_func3), 32'(m.f3));
    chk("mem_rd", 32'(bus.mem_rd), 32'(m.rd));
    chk("mem_result", bus.mem_result, m.res);
    chk("mem_reg_write", 32'(bus.mem_reg_write), 32'(m.rw));
    chk("mem_read", 32'(bus.mem_read), 32'(m.rd_en));
    chk("mem_write", 32'(bus.mem_write), 32'(m.wr));
    chk("mem_wstrb", 32'(bus.mem_wstrb), 32'(m.strb));
    chk("mem_misalign", 32'(bus.mem_misalign), 32'(m.mis));
    if (m.op == OpStore && m.f3 <= 3'd2) chk("mem_wdata", bus.mem_wdata, m.wdata);
  endtask

  task automatic drive(input txn_t t);
    bus.ex_pc       = t.pc;
    bus.ex_opcode   = t.op;
    bus.ex_func3    = t.f3;
    bus.ex_rd       = t.rd;
    bus.ex_rs1_data = t.rs1;
    bus.ex_rs2_data = t.rs2;
    bus.ex_imm      = t.imm;
    bus.alu_out     = t.alu;
  endtask

  // One clock: apply inputs, check ex_ready, advance the model, check registered outputs.
  task automatic cycle(input txn_t t, input bit v, input bit fl, input bit mr);
    bit          ready;
    bit          acc;
    logic [31:0] tgt;
    drive(t);
    bus.ex_valid  = v;
    bus.flush     = fl;
    bus.mem_ready = mr;
    #2;
    ready = !m_valid || mr;
    chk("ex_ready", 32'(bus.ex_ready), 32'(ready));
    acc = v && ready && !r_valid && !fl;
    if (fl) begin
      m_valid = 0;
      r_valid = 0;
    end else if (acc) begin
      m       = predict(t);
      m_valid = 1;
      r_valid = redirects(t, tgt);
      if (r_valid) r_pc = tgt;
    end else begin
      if (m_valid && mr) m_valid = 0;
      r_valid = 0;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  function automatic txn_t mk(input logic [4:0] op, input logic [2:0] f3, input logic [4:0] rd,
                              input logic [31:0] pc, input logic [31:0] rs1,
                              input logic [31:0] rs2, input logic [31:0] imm,
                              input logic [31:0] alu);
    txn_t t;
    t.op = op; t.f3 = f3; t.rd = rd; t.pc = pc;
    t.rs1 = rs1; t.rs2 = rs2; t.imm = imm; t.alu = alu;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.op  = op_list[$urandom_range(0, 8)];
    t.f3  = 3'($urandom_range(0, 7));
    if ((t.op == OpStore || t.op == OpLoad) && $urandom_range(0, 3) != 0)
      t.f3 = 3'($urandom_range(0, 2));
    t.rd  = 5'($urandom_range(0, 31));
    t.pc  = $urandom() & 32'hFFFF_FFFC;
    t.rs1 = $urandom();
    t.rs2 = $urandom();
    t.imm = $urandom();
    t.alu = $urandom();
    return t;
  endfunction

  initial begin
    txn_t add5, idle, t;
    add5 = mk(OpReg, 3'd0, 5'd5, 32'h0, 32'h8, 32'h8, 32'h0, 32'h10);
    idle = mk(OpImm, 3'd0, 5'd1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    bus.flush = 1'b0;
    bus.mem_ready = 1'b1;
    bus.ex_valid = 1'b1;
    drive(add5);
    model_reset();

    // Reset held with a valid instruction offered: everything stays zero.
    rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check_all();
    end
    rst_n = 1'b1;
    cycle(add5, 1, 0, 1);
    chk("first_add_result", bus.mem_result, 32'h10);
    chk("first_add_rw", 32'(bus.mem_reg_write), 32'd1);

    // Four R-type results 1..4 with a two-cycle memory stall after the second.
    cycle(mk(OpReg, 3'd0, 5'd1, 32'h0, 0, 0, 0, 32'd1), 1, 0, 1);
    cycle(mk(OpReg, 3'd0, 5'd2, 32'h4, 0, 0, 0, 32'd2), 1, 0, 1);
    cycle(mk(OpReg, 3'd0, 5'd3, 32'h8, 0, 0, 0, 32'd3), 1, 0, 0);
    chk("stall_ready", 32'(bus.ex_ready), 32'd0);
    chk("stall_hold", bus.mem_result, 32'd2);
    cycle(mk(OpReg, 3'd0, 5'd3, 32'h8, 0, 0, 0, 32'd3), 1, 0, 0);
    cycle(mk(OpReg, 3'd0, 5'd3, 32'h8, 0, 0, 0, 32'd3), 1, 0, 1);
    chk("order_3", bus.mem_result, 32'd3);
    cycle(mk(OpReg, 3'd0, 5'd4, 32'hC, 0, 0, 0, 32'd4), 1, 0, 1);
    chk("order_4", bus.mem_result, 32'd4);
    cycle(idle, 0, 0, 1);

    // Taken beq, then a wrong-path instruction that must be dropped.
    cycle(mk(OpBranch, 3'd0, 5'd0, 32'h100, 0, 0, 32'h20, 32'd1), 1, 0, 1);
    chk("beq_redirect", 32'(bus.redirect_valid), 32'd1);
    chk("beq_target", bus.redirect_pc, 32'h120);
    cycle(mk(OpReg, 3'd0, 5'd7, 32'h104, 0, 0, 0, 32'h77), 1, 0, 1);
    chk("drop_valid", 32'(bus.mem_valid), 32'd0);
    chk("redirect_one_cycle", 32'(bus.redirect_valid), 32'd0);

    // jalr and not-taken bne.
    cycle(mk(OpJalr, 3'd0, 5'd1, 32'h200, 32'h2001, 0, 32'd4, 32'h204), 1, 0, 1);
    chk("jalr_target", bus.redirect_pc, 32'h2004);
    chk("jalr_link", bus.mem_result, 32'h204);
    cycle(idle, 0, 0, 1);
    cycle(mk(OpBranch, 3'd1, 5'd0, 32'h300, 0, 0, 32'h40, 32'd0), 1, 0, 1);
    chk("bne_no_redirect", 32'(bus.redirect_valid), 32'd0);

    // Store formatting.
    cycle(mk(OpStore, 3'd0, 5'd0, 32'h400, 0, 32'hAABBCCDD, 0, 32'h1003), 1, 0, 1);
    chk("sb_wdata", bus.mem_wdata, 32'hDDDDDDDD);
    chk("sb_wstrb", 32'(bus.mem_wstrb), 32'h8);
    cycle(mk(OpStore, 3'd1, 5'd0, 32'h404, 0, 32'h11223344, 0, 32'h1002), 1, 0, 1);
    chk("sh_wstrb", 32'(bus.mem_wstrb), 32'hC);
    cycle(mk(OpStore, 3'd2, 5'd0, 32'h408, 0, 32'h55667788, 0, 32'h1001), 1, 0, 1);
    chk("sw_misalign", 32'(bus.mem_misalign), 32'd1);
    chk("sw_write", 32'(bus.mem_write), 32'd0);

    // Flush in the same cycle as a jal is offered, then an rd=0 add.
    cycle(mk(OpJal, 3'd0, 5'd1, 32'h500, 0, 0, 32'h80, 32'h504), 1, 1, 1);
    chk("flush_valid", 32'(bus.mem_valid), 32'd0);
    chk("flush_redirect", 32'(bus.redirect_valid), 32'd0);
    cycle(mk(OpReg, 3'd0, 5'd0, 32'h600, 0, 0, 0, 32'h99), 1, 0, 1);
    chk("rd0_rw", 32'(bus.mem_reg_write), 32'd0);

    // Stalled jal, then asynchronous reset between edges.
    cycle(idle, 0, 0, 1);
    cycle(mk(OpJal, 3'd0, 5'd1, 32'h700, 0, 0, 32'h10, 32'h704), 1, 0, 0);
    bus.ex_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
    cycle(idle, 0, 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      t = rand_txn();
      cycle(t, $urandom_range(0, 9) < 8, $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
